counter_sched: RTL and testbench



---
 rtl/counter_sched_pkg.sv | 16 +
 rtl/counter_sched_if.sv | 26 ++
 rtl/counter_sched_rr_arbiter.sv | 32 +++
 rtl/counter_sched.sv | 149 ++++++++++++++
 tb/tb_counter_sched.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter_sched block: FSM state encoding,
// counter width default and watchdog limit.
package counter_sched_pkg;

    localparam int WIDTH_DEF  = 4;
    localparam int WDOG_LIMIT = 17;
    localparam int WDOG_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/counter_sched_if.sv
// Requester/counter-side bus of counter_sched; the scheduler uses the slave
// modport, the surrounding logic (requesters + counter) uses master.
interface counter_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = counter_sched_pkg::WIDTH_DEF
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] preset;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  err;
    logic [WIDTH-1:0]      cnt_set;
    logic                  cnt_reset;
    logic                  cnt_carry;

    modport master (
        output req, preset, cnt_carry,
        input  grant, done, busy, err, cnt_set, cnt_reset
    );

    modport slave (
        input  req, preset, cnt_carry,
        output grant, done, busy, err, cnt_set, cnt_reset
    );
endinterface

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester after i_last (wrapping),
// returned as an index and as a one-hot vector.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic [NREQ-1:0]  o_onehot
);
    logic [IDX_W-1:0] w_cand;

    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned infers a latch.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            w_cand = IDX_W'((int'(i_last) + off) % NREQ);
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

    assign o_onehot = o_valid ? (NREQ'(1) << o_idx) : '0;

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one 4-bit wrap counter among NREQ requesters.
// Optional RUN watchdog enabled by defining COUNTER_SCHED_WDOG_EN.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = WIDTH_DEF
) (
    input logic            clk,
    input logic            reset,
    counter_sched_if.slave bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e           r_state;
    state_e           w_next_state;
    logic [IDX_W-1:0] r_owner;
    logic [NREQ-1:0]  r_owner_oh;
    logic [WIDTH-1:0] r_preset;
    logic [IDX_W-1:0] r_last;

    logic             w_arb_valid;
    logic [IDX_W-1:0] w_arb_idx;
    logic [NREQ-1:0]  w_arb_oh;
    logic [WIDTH-1:0] w_preset_sel;

`ifdef COUNTER_SCHED_WDOG_EN
    logic [WDOG_W-1:0] r_wdog;
    logic              r_timeout;
    logic              w_wdog_expire;
`endif

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req    (bus.req),
        .i_last   (r_last),
        .o_valid  (w_arb_valid),
        .o_idx    (w_arb_idx),
        .o_onehot (w_arb_oh)
    );

    always_comb begin
        w_preset_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_arb_idx == IDX_W'(i)) begin
                w_preset_sel = bus.preset[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
`ifdef COUNTER_SCHED_WDOG_EN
        w_wdog_expire = 1'b0;
`endif
        case (r_state)
            ST_IDLE: if (w_arb_valid) w_next_state = ST_LOAD;
            ST_LOAD: w_next_state = ST_RUN;
            ST_RUN: begin
                if (bus.cnt_carry) begin
                    w_next_state = ST_DONE;
                end
`ifdef COUNTER_SCHED_WDOG_EN
                // r_wdog holds the count of RUN cycles already completed.
                else if (r_wdog == WDOG_W'(WDOG_LIMIT - 1)) begin
                    w_next_state  = ST_DONE;
                    w_wdog_expire = 1'b1;
                end
`endif
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_owner_oh <= '0;
            r_preset   <= '0;
            r_last     <= IDX_W'(NREQ - 1);
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && w_arb_valid) begin
                r_owner    <= w_arb_idx;
                r_owner_oh <= w_arb_oh;
                r_preset   <= w_preset_sel;
            end
            if (r_state == ST_DONE) begin
                r_last <= r_owner;
            end
        end
    end

`ifdef COUNTER_SCHED_WDOG_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == ST_LOAD) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_wdog    <= r_wdog + WDOG_W'(1);
            r_timeout <= w_wdog_expire;
        end
    end
`endif

    // All outputs decode from the state register and captured job data.
    always_comb begin
        bus.grant     = '0;
        bus.done      = '0;
        bus.busy      = 1'b0;
        bus.err       = 1'b0;
        bus.cnt_set   = '0;
        bus.cnt_reset = 1'b0;
        case (r_state)
            ST_IDLE: bus.cnt_reset = 1'b1;
            ST_LOAD: begin
                bus.grant = r_owner_oh;
                bus.busy  = 1'b1;
                // The counter cannot load 0 through set, so reset instead.
                if (r_preset != '0) bus.cnt_set   = r_preset;
                else                bus.cnt_reset = 1'b1;
            end
            ST_RUN: begin
                bus.grant = r_owner_oh;
                bus.busy  = 1'b1;
            end
            ST_DONE: begin
                bus.grant     = r_owner_oh;
                bus.done      = r_owner_oh;
                bus.busy      = 1'b1;
                bus.cnt_reset = 1'b1;
`ifdef COUNTER_SCHED_WDOG_EN
                bus.err       = r_timeout;
`endif
            end
            default: bus.cnt_reset = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched: directed jobs then random traffic,
// compared each cycle against a job-timeline reference model.
module tb_counter_sched;
    import counter_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic carry_kill;

    counter_sched_if #(.NREQ(NREQ), .WIDTH(W)) cif ();

    counter_sched #(.NREQ(NREQ), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (cif.slave)
    );

    // Behavioural 4-bit wrap counter standing in for the external instance.
    logic [W-1:0] c_val;
    logic         c_carry;
    always @(posedge clk) begin
        if (cif.cnt_reset) begin
            c_val   <= '0;
            c_carry <= 1'b0;
        end else if (cif.cnt_set != '0) begin
            c_val   <= cif.cnt_set;
            c_carry <= 1'b0;
        end else begin
            c_val <= c_val + 1'b1;
            if (c_val == '1) c_carry <= 1'b1;
        end
    end
    assign cif.cnt_carry = c_carry & ~carry_kill;

    int total = 0;
    int bad   = 0;

    // Reference model: a job is a window of m_len cycles after the sampling
    // edge; phase m_k counts cycles into it (0 = no job).
    int m_k, m_len, m_owner, m_p, m_last;
    bit m_err;

`ifdef COUNTER_SCHED_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit found;
        if (!reset) begin
            m_k    = 0;
            m_last = NREQ - 1;
        end else if (m_k == 0) begin
            if (cif.req != '0) begin
                found = 1'b0;
                for (int off = 1; off <= NREQ; off++) begin
                    if (!found && cif.req[(m_last + off) % NREQ]) begin
                        found   = 1'b1;
                        m_owner = (m_last + off) % NREQ;
                    end
                end
                m_p   = int'(cif.preset[m_owner*W +: W]);
                m_err = carry_kill && WDOG;
                // LOAD + (16-P) counting cycles + 1 cycle to see carry + DONE.
                if (carry_kill) m_len = WDOG ? (1 + WDOG_LIMIT + 1) : 100000;
                else            m_len = 19 - m_p;
                m_k = 1;
            end
        end else if (m_k < m_len) begin
            m_k++;
        end else begin
            m_k    = 0;
            m_last = m_owner;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [NREQ-1:0] e_oh;
        e_oh = (m_k > 0) ? (NREQ'(1) << m_owner) : '0;
        check({tag, ".grant"}, 32'(cif.grant), 32'(e_oh));
        check({tag, ".done"}, 32'(cif.done), (m_k > 0 && m_k == m_len) ? 32'(e_oh) : 32'd0);
        check({tag, ".busy"}, 32'(cif.busy), 32'(m_k > 0));
        check({tag, ".err"}, 32'(cif.err), 32'(m_err && m_k > 0 && m_k == m_len));
        check({tag, ".cnt_set"}, 32'(cif.cnt_set), (m_k == 1 && m_p != 0) ? 32'(m_p) : 32'd0);
        check({tag, ".cnt_reset"}, 32'(cif.cnt_reset),
              32'((m_k == 0) || (m_k == m_len) || (m_k == 1 && m_p == 0)));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic set_preset(input int idx, input int val);
        cif.preset[idx*W +: W] = W'(val);
    endtask

    initial begin
        reset      = 1'b0;
        carry_kill = 1'b0;
        cif.req    = '0;
        cif.preset = '0;
        m_k = 0; m_len = 0; m_owner = 0; m_p = 0; m_last = NREQ - 1; m_err = 1'b0;

        steps("rst", 3);
        reset = 1'b1;
        steps("idle", 2);

        // Requester 0, preset 5: 11 counting cycles, done after E13.
        set_preset(0, 5);
        cif.req = 4'b0001;
        step("p5");
        cif.req = '0;
        steps("p5", 16);

        // Requester 2, preset 0: loaded through reset, done after E18.
        set_preset(2, 0);
        cif.req = 4'b0100;
        step("p0");
        cif.req = '0;
        steps("p0", 21);

        // All requesting with preset 15 from a fresh reset: order 0,1,2,3,0.
        reset = 1'b0;
        step("rr_rst");
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) set_preset(i, 15);
        cif.req = 4'b1111;
        steps("rr", 25);
        cif.req = '0;
        steps("rr_tail", 6);

        // Requester 1 drops req mid-job; the job still completes.
        set_preset(1, 10);
        cif.req = 4'b0010;
        steps("drop", 5);
        cif.req = '0;
        steps("drop", 12);

        // Reset in the middle of RUN.
        set_preset(0, 3);
        cif.req = 4'b0001;
        steps("rst_run", 6);
        cif.req = '0;
        reset = 1'b0;
        steps("rst_run", 2);
        reset = 1'b1;
        steps("rst_run", 3);

        // Carry never arrives: watchdog ends the job, or RUN holds until reset.
        carry_kill = 1'b1;
        set_preset(0, 5);
        cif.req = 4'b0001;
        step("stuck");
        cif.req = '0;
        steps("stuck", 24);
        reset = 1'b0;
        steps("stuck_rst", 2);
        reset      = 1'b1;
        carry_kill = 1'b0;
        steps("stuck_rst", 2);

        // Random traffic: requests, presets and occasional resets change freely.
        for (int c = 0; c < 700; c++) begin
            if ($urandom_range(3) == 0) cif.req = NREQ'($urandom);
            if ($urandom_range(2) == 0) cif.preset = (NREQ*W)'($urandom);
            reset = ($urandom_range(199) == 0) ? 1'b0 : 1'b1;
            step("rand");
        end
        reset   = 1'b1;
        cif.req = '0;
        steps("drain", 22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
